intr_sched: RTL and testbench
=============================

Name: intr_sched

Overview:
Interrupt scheduler placed between the peripheral event sources (UART receive-complete, timer compare match, spares) and the CPU interrupt entry logic on the mother board. It latches one-cycle event pulses into pending flags and applies the enable mask written by W_INTR. It arbitrates by fixed priority and hands one interrupt at a time to the CPU through a req/ack handshake. It then blocks further requests until the CPU executes IRET. Interrupts do not nest.

Parameters:
N_SRC, 4, number of interrupt sources, 2..16; index 0 is highest priority.
VEC_BASE, 32'h0000_0100, handler address of source 0.
VEC_STRIDE, 32'h0000_0010, address spacing between consecutive source handlers.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
src_pulse  in  N_SRC  one-cycle event pulse per source
mask_we  in  1  write strobe for enable mask (W_INTR)
mask_wdata  in  N_SRC  new enable mask, 1 = enabled
ovr_clr  in  1  clears overrun flags (optional feature)
intr_ack  in  1  CPU accepted the request, one cycle
iret  in  1  CPU executed IRET, one cycle
intr_req  out  1  interrupt request to CPU
intr_id  out  $clog2(N_SRC)  granted source index
intr_vec  out  32  handler address = VEC_BASE + intr_id*VEC_STRIDE, truncated to 32 bits
in_service  out  1  handler active
mask  out  N_SRC  current enable mask
pending  out  N_SRC  current pending flags
overrun  out  N_SRC  sticky overrun flags (optional feature)

Behaviour:
- Single clock. Reset is synchronous and active-high. All registers update on the rising edge of clk.
- Reset values: state IDLE; intr_req 0; intr_id 0; intr_vec VEC_BASE; in_service 0; mask 0; pending 0; overrun 0.
- Pending flags:
  - pending[i] sets on any cycle where src_pulse[i]=1, regardless of mask.
  - pending[i] clears only on acceptance of source i.
  - If a pulse and acceptance of the same source fall in the same cycle, the set wins and pending[i] stays 1.
- Mask: on mask_we, mask <= mask_wdata on the next edge. Masked pending flags are retained and become eligible once unmasked.
- Eligibility: elig = pending & mask. The winner is the lowest set index of elig.
- State IDLE:
  - If elig != 0, go to REQ on the next edge.
  - On that edge, latch intr_id = winner and intr_vec, and set intr_req = 1.
  - Latency: pulse sampled at edge k, pending visible after edge k, intr_req high after edge k+1 when already enabled.
- State REQ:
  - intr_req stays high; intr_id and intr_vec are held stable.
  - intr_ack=1: clear pending[intr_id], drop intr_req, set in_service, go to SERVICE.
  - A higher-priority source becoming eligible while in REQ does not preempt the latched id.
  - If mask_we clears mask[intr_id] while intr_ack=0: drop intr_req and return to IDLE. The pending flag is kept.
  - If intr_ack and mask_we arrive in the same cycle, the ack wins.
- State SERVICE:
  - intr_req is held at 0.
  - iret=1: clear in_service and go to IDLE. The earliest new intr_req is one cycle after IDLE is entered.
- Ignored inputs: intr_ack outside REQ; iret outside SERVICE.
- Reset asserted in any state returns all registers to their reset values on that edge. Events pulsed in that cycle are lost.
- intr_id and intr_vec keep their last values when not in REQ or SERVICE.

Optional Feature:
INTR_SCHED_OVERRUN_EN
- Defined:
  - overrun[i] sets when src_pulse[i]=1 while pending[i] is already 1 and source i is not being accepted in that cycle.
  - The flag is sticky and is cleared by ovr_clr. If ovr_clr and a set condition occur in the same cycle, the set wins.
- Undefined: overrun is tied to 0, ovr_clr is ignored, and no overrun logic is generated. The port list is unchanged.

Test Plan:
- Reset, then mask_wdata=4'b0011 and src_pulse=4'b0010 at cycle 5 -> pending=4'b0010 after cycle 5; intr_req=1, intr_id=1, intr_vec=32'h110 after cycle 6.
- Pulses on sources 3 and 0 in the same cycle with mask=4'b1111 -> id 0 is granted first. After ack and iret, id 3 is requested with vec=32'h130.
- Pulse on source 2 with mask=0 -> no intr_req. Writing mask=4'b0100 afterwards -> intr_req two cycles later with id 2.
- In REQ with id 1, write mask=4'b0000 with intr_ack=0 -> intr_req=0 next cycle and pending[1] stays 1. In a separate run, intr_ack and the same pulse in one cycle -> SERVICE entered and pending[1] stays 1.
- In SERVICE, a pulse on source 0 -> no intr_req until iret. Asserting intr_ack in SERVICE -> ignored. After iret -> request for id 0.
- With INTR_SCHED_OVERRUN_EN defined, two pulses on source 1 before ack -> overrun=4'b0010, cleared by ovr_clr. Without the macro -> overrun stays 0.

Source files
------------

// File: rtl/intr_sched.sv
// intr_sched: fixed-priority, non-nesting interrupt scheduler with a req/ack/iret CPU handshake.
// Optional sticky overrun flags are enabled by defining INTR_SCHED_OVERRUN_EN.
`default_nettype none

module intr_sched #(
  parameter int          N_SRC      = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
  localparam int         IDW        = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_pulse,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             ovr_clr,
  input  logic             intr_ack,
  input  logic             iret,
  output logic             intr_req,
  output logic [IDW-1:0]   intr_id,
  output logic [31:0]      intr_vec,
  output logic             in_service,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_req;
  logic [IDW-1:0]   r_id;
  logic [31:0]      r_vec;
  logic             r_insvc;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_pending;

  logic [N_SRC-1:0] w_elig;
  logic [IDW-1:0]   w_win;
  logic [31:0]      w_vec;
  logic             w_accept;
  logic [N_SRC-1:0] w_acc;

  assign w_elig   = r_pending & r_mask;
  assign w_accept = (r_state == S_REQ) && intr_ack;
  assign w_acc    = w_accept ? ({{(N_SRC-1){1'b0}}, 1'b1} << r_id) : '0;
  assign w_vec    = VEC_BASE + (32'(w_win) * VEC_STRIDE);

  // Scan downward so the lowest set index is the one left standing.
  always_comb begin
    w_win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = IDW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_id      <= '0;
      r_vec     <= VEC_BASE;
      r_insvc   <= 1'b0;
      r_mask    <= '0;
      r_pending <= '0;
    end else begin
      // A new pulse outranks the clear from acceptance of the same source.
      r_pending <= (r_pending & ~w_acc) | src_pulse;
      if (mask_we) r_mask <= mask_wdata;
      case (r_state)
        S_IDLE: begin
          if (|w_elig) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_id    <= w_win;
            r_vec   <= w_vec;
          end
        end
        S_REQ: begin
          if (intr_ack) begin
            r_req   <= 1'b0;
            r_insvc <= 1'b1;
            r_state <= S_SVC;
          end else if (mask_we && !mask_wdata[r_id]) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SVC: begin
          if (iret) begin
            r_insvc <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef INTR_SCHED_OVERRUN_EN
  logic [N_SRC-1:0] r_overrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= '0;
    end else begin
      r_overrun <= (ovr_clr ? '0 : r_overrun) | (src_pulse & r_pending & ~w_acc);
    end
  end

  assign overrun = r_overrun;
`else
  logic w_unused_ovr_clr;
  assign w_unused_ovr_clr = ovr_clr;
  assign overrun          = '0;
`endif

  assign intr_req   = r_req;
  assign intr_id    = r_id;
  assign intr_vec   = r_vec;
  assign in_service = r_insvc;
  assign mask       = r_mask;
  assign pending    = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_intr_sched.sv
// tb_intr_sched: directed and randomized stimulus for intr_sched, checked by a queue-based scoreboard.
`default_nettype none

module tb_intr_sched;
  localparam int          N  = 4;
  localparam logic [31:0] VB = 32'h0000_0100;
  localparam logic [31:0] VS = 32'h0000_0010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic [N-1:0] src_pulse = '0;
  logic         mask_we = 1'b0;
  logic [N-1:0] mask_wdata = '0;
  logic         ovr_clr = 1'b0;
  logic         intr_ack = 1'b0;
  logic         iret = 1'b0;
  logic         intr_req;
  logic [1:0]   intr_id;
  logic [31:0]  intr_vec;
  logic         in_service;
  logic [N-1:0] mask;
  logic [N-1:0] pending;
  logic [N-1:0] overrun;

  intr_sched #(.N_SRC(N), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk(clk), .reset(reset), .src_pulse(src_pulse), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .ovr_clr(ovr_clr), .intr_ack(intr_ack), .iret(iret),
    .intr_req(intr_req), .intr_id(intr_id), .intr_vec(intr_vec),
    .in_service(in_service), .mask(mask), .pending(pending), .overrun(overrun)
  );

  typedef struct {
    logic         req;
    logic         svc;
    logic [1:0]   id;
    logic [31:0]  vec;
    logic [N-1:0] pend;
    logic [N-1:0] msk;
    logic [N-1:0] ovr;
  } st_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] vec;
  } gr_t;

  st_t stq[$];
  gr_t grq[$];
  int  checks   = 0;
  int  failures = 0;

  // Reference model: 0 = waiting, 1 = requesting, 2 = handler running.
  int           m_state = 0;
  int           m_id    = 0;
  logic [N-1:0] m_pend  = '0;
  logic [N-1:0] m_mask  = '0;
  logic [N-1:0] m_ovr   = '0;

  function automatic logic [31:0] vec_of(input int id);
    return VB + 32'(id) * VS;
  endfunction

  task automatic model_step();
    logic [N-1:0] accm;
    logic [N-1:0] elig;
    if (reset) begin
      m_state = 0; m_id = 0; m_pend = '0; m_mask = '0; m_ovr = '0;
    end else begin
      accm = (m_state == 1 && intr_ack) ? N'(1 << m_id) : '0;
`ifdef INTR_SCHED_OVERRUN_EN
      m_ovr = (ovr_clr ? '0 : m_ovr) | (src_pulse & m_pend & ~accm);
`endif
      elig = m_pend & m_mask;
      case (m_state)
        0: if (elig != 0) begin
          for (int i = N - 1; i >= 0; i--) if (elig[i]) m_id = i;
          m_state = 1;
          grq.push_back('{id: 2'(m_id), vec: vec_of(m_id)});
        end
        1: if (intr_ack) m_state = 2;
           else if (mask_we && !mask_wdata[m_id]) m_state = 0;
        default: if (iret) m_state = 0;
      endcase
      m_pend = (m_pend & ~accm) | src_pulse;
      if (mask_we) m_mask = mask_wdata;
    end
    stq.push_back('{req: (m_state == 1), svc: (m_state == 2), id: 2'(m_id),
                    vec: vec_of(m_id), pend: m_pend, msk: m_mask, ovr: m_ovr});
  endtask

  // Drive one cycle of inputs from the falling edge, then advance the model on the rising edge.
  task automatic cyc(input logic [N-1:0] p, input logic mwe, input logic [N-1:0] mwd,
                     input logic ack, input logic ir, input logic oc, input logic rst);
    reset = rst; src_pulse = p; mask_we = mwe; mask_wdata = mwd;
    intr_ack = ack; iret = ir; ovr_clr = oc;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wmask(input logic [N-1:0] m);
    cyc('0, 1'b1, m, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse(input logic [N-1:0] p);
    cyc(p, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ack_c();
    cyc('0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic iret_c();
    cyc('0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: compares every presented status word and every new request against the queues.
  initial begin : monitor
    st_t e;
    gr_t g;
    logic prev_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stq.size() > 0) begin
        e = stq.pop_front();
        checks++;
        if (intr_req !== e.req || in_service !== e.svc || intr_id !== e.id ||
            intr_vec !== e.vec || pending !== e.pend || mask !== e.msk || overrun !== e.ovr) begin
          failures++;
          $display("FAIL status t=%0t got req=%b svc=%b id=%0d vec=%h pend=%b mask=%b ovr=%b exp req=%b svc=%b id=%0d vec=%h pend=%b mask=%b ovr=%b",
                   $time, intr_req, in_service, intr_id, intr_vec, pending, mask, overrun,
                   e.req, e.svc, e.id, e.vec, e.pend, e.msk, e.ovr);
        end
      end
      if (intr_req === 1'b1 && prev_req === 1'b0) begin
        checks++;
        if (grq.size() == 0) begin
          failures++;
          $display("FAIL grant t=%0t got id=%0d vec=%h exp none", $time, intr_id, intr_vec);
        end else begin
          g = grq.pop_front();
          if (intr_id !== g.id || intr_vec !== g.vec) begin
            failures++;
            $display("FAIL grant t=%0t got id=%0d vec=%h exp id=%0d vec=%h",
                     $time, intr_id, intr_vec, g.id, g.vec);
          end
        end
      end
      prev_req = intr_req;
    end
  end

  initial begin : driver
    logic ack_r, ir_r;
    @(negedge clk);
    cyc('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    // Basic grant of source 1.
    wmask(4'b0011); pulse(4'b0010); idle(2); ack_c(); idle(1); iret_c(); idle(1);
    // Simultaneous sources 3 and 0: 0 first, then 3.
    wmask(4'b1111); pulse(4'b1001); idle(2); ack_c(); iret_c(); idle(2); ack_c(); iret_c(); idle(1);
    // Masked pulse held until unmasked.
    wmask(4'b0000); pulse(4'b0100); idle(3); wmask(4'b0100); idle(3); ack_c(); iret_c();
    // Cancel by mask write during REQ, then ack racing a pulse on the same source.
    wmask(4'b0011); pulse(4'b0010); idle(2); wmask(4'b0000); idle(2); wmask(4'b0011); idle(3);
    cyc(4'b0010, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Pulse and stray ack during service, then two queued grants.
    pulse(4'b0001); idle(2); ack_c(); idle(2); iret_c(); idle(2); ack_c(); iret_c(); idle(2); ack_c(); iret_c(); idle(1);
    // Repeated pulse before ack, then overrun clear.
    pulse(4'b0010); pulse(4'b0010); idle(1); ack_c(); iret_c();
    cyc('0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0); idle(2);
    // Mid-request reset drops everything.
    pulse(4'b0001); idle(2);
    cyc(4'b1111, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1); idle(2);
    for (int n = 0; n < 3000; n++) begin
      ack_r = (m_state == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      ir_r  = (m_state == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      cyc(4'($urandom) & 4'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom),
          ack_r, ir_r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 299) == 0));
    end
    idle(3);
    checks++;
    if (grq.size() != 0 || stq.size() != 0) begin
      failures++;
      $display("FAIL drain got grants=%0d status=%0d left exp 0", grq.size(), stq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
